// File: rtl/rsa_xcel_mont_mont_mul_seq.sv
// Purpose: iterative Montgomery multiply sequencer; feeds p_nsteps x-bits per step transaction, then final subtract.
// Latency: 2*(32/p_nsteps)+1 cycles from input fire to ostream_val with an always-ready single-cycle step stage.
// Backpressure: holds ISSUE/WAIT/DONE on step/consumer stalls; optional perf_cycles under RSA_XCEL_MONT_SEQ_PERF_EN.
module rsa_xcel_mont_mont_mul_seq #(
    parameter int p_nsteps = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                istream_val,
    output logic                istream_rdy,
    input  logic [31:0]         x,
    input  logic [31:0]         y,
    input  logic [31:0]         n,
    output logic [p_nsteps-1:0] step_x_bits,
    output logic [31:0]         step_y,
    output logic [31:0]         step_n,
    output logic [32:0]         step_result_in,
    output logic                step_istream_val,
    input  logic                step_istream_rdy,
    input  logic [32:0]         step_result_out,
    input  logic                step_ostream_val,
    output logic                step_ostream_rdy,
    output logic [31:0]         result,
    output logic                ostream_val,
    input  logic                ostream_rdy
`ifdef RSA_XCEL_MONT_SEQ_PERF_EN
    ,
    output logic [15:0]         perf_cycles
`endif
);

    localparam int NITER = 32 / p_nsteps;
    localparam int CW    = $clog2(NITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(NITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [31:0]   x_sh;
    logic [31:0]   y_r;
    logic [31:0]   n_r;
    logic [32:0]   acc;
    logic [CW-1:0] cnt;
    logic [31:0]   result_r;

    // Accumulator is < 2n, so one conditional subtract fully reduces it;
    // the low 32 bits of the 33-bit difference are all that is kept.
    logic          final_ge;
    logic [31:0]   final_sub;
    logic          last_step;

    assign final_ge  = step_result_out >= {1'b0, n_r};
    assign final_sub = step_result_out[31:0] - n_r;
    assign last_step = (state == S_WAIT) && step_ostream_val && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            x_sh     <= '0;
            y_r      <= '0;
            n_r      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (istream_val) begin
                        x_sh  <= x;
                        y_r   <= y;
                        n_r   <= n;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (step_istream_rdy) begin
                        x_sh  <= x_sh >> p_nsteps;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (step_ostream_val) begin
                        acc <= step_result_out;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            result_r <= final_ge ? final_sub : step_result_out[31:0];
                            state    <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (ostream_rdy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign istream_rdy      = (state == S_IDLE);
    assign step_istream_val = (state == S_ISSUE);
    assign step_ostream_rdy = (state == S_WAIT);
    assign ostream_val      = (state == S_DONE);
    assign step_x_bits      = x_sh[p_nsteps-1:0];
    assign step_y           = y_r;
    assign step_n           = n_r;
    assign step_result_in   = acc;
    assign result           = result_r;

`ifdef RSA_XCEL_MONT_SEQ_PERF_EN
    // Counts every busy (ISSUE/WAIT) cycle; the final WAIT cycle is the one that enters DONE.
    logic [15:0] perf_cnt;
    logic [15:0] perf_r;
    logic [15:0] perf_inc;

    assign perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt <= '0;
            perf_r   <= '0;
        end else if ((state == S_IDLE) && istream_val) begin
            perf_cnt <= '0;
        end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
            perf_cnt <= perf_inc;
            if (last_step) begin
                perf_r <= perf_inc;
            end
        end
    end

    assign perf_cycles = perf_r;
`endif

endmodule
